// File: rtl/lsu_subword_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_subword_ctrl
//   Load/store unit in front of a word-addressed data memory (DMEM).
//   Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word DMEM
//   accesses. Loads get lane extraction plus sign/zero extension. Sub-word
//   stores are done as read-modify-write. Misaligned, illegal-funct3 and
//   out-of-range requests are answered with a fault and never reach DMEM.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/ready request handshake (ready only while idle)
//   req_we          1 = store, 0 = load
//   req_funct3      RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr        byte address
//   req_wdata       store data (low byte/half for SB/SH)
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       extended load result; 0 for stores and faults
//   rsp_fault       access aborted (qualified by rsp_valid)
//   mem_read/write  DMEM strobes, never both high
//   mem_addr        word-aligned DMEM address
//   mem_wdata       DMEM write data
//   mem_rdata       DMEM read data (combinational, 0 when mem_read=0)
// ---------------------------------------------------------------------------
module lsu_subword_ctrl #(
    parameter int unsigned DMEM_WORDS   = 256,
    parameter bit          FAULT_ON_OOR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned LP_DW = 32;
    // 33 bits so a full 4 GiB limit cannot wrap to zero
    localparam logic [32:0] LP_BYTE_LIMIT = 33'(DMEM_WORDS) << 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_FAULT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_we;
    logic [2:0]         r_funct3;
    logic [31:0]        r_addr;
    logic [LP_DW-1:0]   r_wdata;
    // load result in LOAD, merged store word in RMW_RD
    logic [LP_DW-1:0]   r_data;

    logic               w_accept;
    logic               w_misaligned;
    logic               w_illegal;
    logic               w_oor;
    logic               w_fault;
    logic [4:0]         w_lane_sh;
    logic [LP_DW-1:0]   w_shifted;
    logic [LP_DW-1:0]   w_load_ext;
    logic [LP_DW-1:0]   w_mask;
    logic [LP_DW-1:0]   w_merged;

    assign w_accept = req_valid & (r_state == S_IDLE);

    // Accept-time fault checks on the raw request
    always_comb begin
        w_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    // Stores allow only 000/001/010; loads reject 011/110/111
    assign w_illegal = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                              : ((req_funct3[1:0] == 2'b11) | (req_funct3[2:1] == 2'b11));

    assign w_oor   = FAULT_ON_OOR & ({1'b0, req_addr} >= LP_BYTE_LIMIT);
    assign w_fault = w_misaligned | w_illegal | w_oor;

    // Little-endian lane select; aligned halves make 8*addr[1:0] == 16*addr[1]
    assign w_lane_sh = {r_addr[1:0], 3'b000};
    assign w_shifted = mem_rdata >> w_lane_sh;

    always_comb begin
        w_load_ext = w_shifted;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_ext = {24'h000000, w_shifted[7:0]};
            3'b101:  w_load_ext = {16'h0000,   w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    // Replace the addressed byte/half of the old word with store data
    assign w_mask   = r_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    assign w_merged = (mem_rdata & ~(w_mask << w_lane_sh))
                    | ((r_wdata & w_mask) << w_lane_sh);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_next = S_FAULT;
                    end else if (!req_we) begin
                        w_next = S_LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        w_next = S_STORE;
                    end else begin
                        w_next = S_RMW_RD;
                    end
                end
            end
            S_LOAD:   w_next = S_RESP;
            S_STORE:  w_next = S_RESP;
            S_RMW_RD: w_next = S_RMW_WR;
            S_RMW_WR: w_next = S_RESP;
            S_FAULT:  w_next = S_IDLE;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request latch and data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= '0;
            r_data   <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_data   <= '0;
            end else if (r_state == S_LOAD) begin
                r_data   <= w_load_ext;
            end else if (r_state == S_RMW_RD) begin
                r_data   <= w_merged;
            end
        end
    end

    // Output decode from state and latched registers only
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_fault = 1'b0;
        rsp_rdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_LOAD, S_RMW_RD: begin
                mem_read = 1'b1;
                mem_addr = {r_addr[31:2], 2'b00};
            end
            S_STORE: begin
                mem_write = 1'b1;
                mem_addr  = {r_addr[31:2], 2'b00};
                mem_wdata = r_wdata;
            end
            S_RMW_WR: begin
                mem_write = 1'b1;
                mem_addr  = {r_addr[31:2], 2'b00};
                mem_wdata = r_data;
            end
            S_FAULT: begin
                rsp_valid = 1'b1;
                rsp_fault = 1'b1;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = r_we ? '0 : r_data;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_subword_ctrl
//   Bench for lsu_subword_ctrl: a behavioural DMEM, a shadow memory holding
//   what DMEM must contain in program order, and a request task that checks
//   every cycle of a transaction against the expected response.
// ---------------------------------------------------------------------------
module tb_lsu_subword_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    bit g_hold = 1'b0;

    logic [31:0] dmem   [256];
    logic [31:0] shadow [256];

    lsu_subword_ctrl #(.DMEM_WORDS(256), .FAULT_ON_OOR(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DMEM: combinational read, write on the rising edge
    assign mem_rdata = mem_read ? dmem[mem_addr[9:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---- reference model ----
    function automatic bit m_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        case (f3)
            3'd0:    sz = 1;
            3'd1:    sz = 2;
            3'd2:    sz = 4;
            3'd4:    sz = we ? 0 : 1;
            3'd5:    sz = we ? 0 : 2;
            default: sz = 0;
        endcase
        if (sz == 0) return 1'b1;
        if ((a % sz) != 0) return 1'b1;
        if (a >= 32'd1024) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v & 32'd255;   if (v >= 32'd128)   v = v | 32'hFFFF_FF00; end
            3'd1: begin v = v & 32'd65535; if (v >= 32'd32768) v = v | 32'hFFFF_0000; end
            3'd4: v = v & 32'd255;
            3'd5: v = v & 32'd65535;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int unsigned sh;
        mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
        sh   = 8 * (a % 4);
        return (w & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    // Issue one request and check every cycle up to and including the response
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] o_rd,
                          output logic o_f, output int o_lat, output logic [31:0] o_wd);
        bit          ef;
        logic [31:0] er;
        logic [31:0] ew;
        int          el;
        int          erd;
        int          ewr;
        int          nrd;
        int          nwr;
        int          idx;
        bit          done;
        ef  = m_fault(we, f3, a);
        idx = int'(a[9:2]);
        er  = 32'h0;
        ew  = 32'h0;
        if (ef) begin
            el = 1; erd = 0; ewr = 0;
        end else if (!we) begin
            el = 2; erd = 1; ewr = 0;
            er = m_load(shadow[idx], f3, a);
        end else if (f3 == 3'd2) begin
            el = 2; erd = 0; ewr = 1;
            ew = wd;
            shadow[idx] = ew;
        end else begin
            el = 3; erd = 1; ewr = 1;
            ew = m_merge(shadow[idx], f3, a, wd);
            shadow[idx] = ew;
        end

        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        if (!g_hold) req_valid = 1'b0;
        // junk on the bus: the DUT must work from its latched copy
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        nrd = 0; nwr = 0; done = 1'b0;
        o_rd = 32'h0; o_f = 1'b0; o_lat = 0; o_wd = 32'h0;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (mem_read || mem_write) chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                o_wd = mem_wdata;
            end
            if (rsp_valid) begin
                done  = 1'b1;
                o_lat = c;
                o_f   = rsp_fault;
                o_rd  = rsp_rdata;
            end else begin
                chk("req_ready_busy", 32'(req_ready), 32'd0);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got=no rsp_valid expected=rsp within 8 cycles at %0t", $time);
        end
        chk("latency",   32'(o_lat), 32'(el));
        chk("rsp_fault", 32'(o_f),   32'(ef));
        chk("rsp_rdata", o_rd,       er);
        chk("n_reads",   32'(nrd),   32'(erd));
        chk("n_writes",  32'(nwr),   32'(ewr));
        if (ewr != 0) chk("mem_wdata", o_wd, ew);
    endtask

    logic [31:0] rd;
    logic        f;
    int          lat;
    logic [31:0] wdo;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom;
            dmem[i]   <= v;
            shadow[i] = v;
        end
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_rw",    32'({mem_read, mem_write}), 32'd0);
        chk("rst_mem_addr",  mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // word store then load
        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, f, lat, wdo);
        chk("t1_sw_wdata", wdo, 32'hDEAD_BEEF);
        chk("t1_sw_lat", 32'(lat), 32'd2);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, f, lat, wdo);
        chk("t1_lw_rdata", rd, 32'hDEAD_BEEF);
        chk("t1_lw_lat", 32'(lat), 32'd2);

        // byte store then byte loads
        do_req(1'b1, 3'd0, 32'h12, 32'h1234_565A, rd, f, lat, wdo);
        chk("t2_sb_wdata", wdo, 32'hDE5A_BEEF);
        chk("t2_sb_lat", 32'(lat), 32'd3);
        do_req(1'b0, 3'd0, 32'h12, 32'h0, rd, f, lat, wdo);
        chk("t2_lb_12", rd, 32'h0000_005A);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, rd, f, lat, wdo);
        chk("t2_lbu_13", rd, 32'h0000_00DE);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, rd, f, lat, wdo);
        chk("t2_lb_13", rd, 32'hFFFF_FFDE);

        // half store then half loads
        do_req(1'b1, 3'd1, 32'h12, 32'hABCD_8001, rd, f, lat, wdo);
        chk("t3_sh_wdata", wdo, 32'h8001_BEEF);
        chk("t3_sh_lat", 32'(lat), 32'd3);
        do_req(1'b0, 3'd1, 32'h12, 32'h0, rd, f, lat, wdo);
        chk("t3_lh", rd, 32'hFFFF_8001);
        do_req(1'b0, 3'd5, 32'h12, 32'h0, rd, f, lat, wdo);
        chk("t3_lhu", rd, 32'h0000_8001);

        // faults
        do_req(1'b0, 3'd2, 32'h11, 32'h0, rd, f, lat, wdo);
        chk("t4_lw_mis", 32'({f, 4'(lat)}), 32'h11);
        do_req(1'b1, 3'd1, 32'h13, 32'h5555, rd, f, lat, wdo);
        chk("t4_sh_mis", 32'({f, 4'(lat)}), 32'h11);
        do_req(1'b0, 3'd3, 32'h0, 32'h0, rd, f, lat, wdo);
        chk("t4_f3_011", 32'({f, 4'(lat)}), 32'h11);
        do_req(1'b0, 3'd2, 32'h400, 32'h0, rd, f, lat, wdo);
        chk("t4_lw_oor", 32'({f, 4'(lat)}), 32'h11);
        do_req(1'b1, 3'd4, 32'h20, 32'h0, rd, f, lat, wdo);
        chk("t4_st_f3_100", 32'(f), 32'd1);

        // back-to-back loads with req_valid held high
        g_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, 3'(i % 2 == 0 ? 2 : 4), 32'(4 * i + (i % 2)), 32'h0, rd, f, lat, wdo);
        end
        g_hold = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;

        // reset during RMW_RD leaves memory untouched, no response
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h10;
        req_wdata  = 32'h0000_0077;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("t6_in_rmw_rd", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rw",    32'({mem_read, mem_write}), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd1);
        chk("t6_rst_rsp",   32'(rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", 32'(rsp_valid | mem_write), 32'd0);
        end
        rst_n = 1'b1;
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, f, lat, wdo);
        chk("t6_lw_prior", rd, 32'h8001_BEEF);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit          we;
            logic [2:0]  f3;
            logic [31:0] a;
            int          r;
            we = 1'($urandom);
            r  = int'($urandom_range(0, 9));
            if (r == 0) f3 = 3'($urandom);
            else begin
                int k;
                k  = int'($urandom_range(0, 4));
                f3 = (k == 3) ? 3'd4 : (k == 4) ? 3'd5 : 3'(k);
            end
            r = int'($urandom_range(0, 19));
            if (r == 0) a = $urandom;
            else if (r == 1) a = 32'(1020 + $urandom_range(0, 8));
            else a = 32'($urandom_range(0, 1023));
            if (r > 4) a = a & ~((f3[1:0] == 2'b10) ? 32'h3 : (f3[1:0] == 2'b01) ? 32'h1 : 32'h0);
            g_hold = 1'($urandom);
            do_req(we, f3, a, $urandom, rd, f, lat, wdo);
        end
        g_hold = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 256; i++) begin
            chk("dmem_final", dmem[i], shadow[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
